traffic_ctrl: RTL and testbench
===============================

# traffic_ctrl

Pedestrian-priority traffic light sequencer for a single crossing. It generates its own 1 s tick enable from the 100 MHz system clock and runs a Moore FSM that drives the car and pedestrian lamps. A latched pedestrian request cuts the car green short once the minimum green time has elapsed. It sits directly under the board top, with lamp outputs wired to LEDs and `ped_btn` wired to a push-button.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per tick (1 s at 100 MHz); set to 4 for simulation.
- `T_GREEN_MIN`, 10: minimum car green, in ticks.
- `T_YELLOW`, 3: car yellow, in ticks.
- `T_ALL_RED`, 1: all-red clearance, in ticks.
- `T_WALK`, 8: steady pedestrian green, in ticks.
- `T_FLASH`, 4: flashing pedestrian green, in ticks.
- All `T_*` parameters are in the range 1..255.

Ports:
- `clk_100MHz`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ped_btn`  in  1: pedestrian button; asynchronous, level.
- `emergency`  in  1: emergency all-red request; asynchronous; present only with `EMERGENCY_EN`.
- `car_red`, `car_yellow`, `car_green`  out  1 each: car lamps.
- `ped_red`, `ped_green`  out  1 each: pedestrian lamps.
- `ped_wait`  out  1: request-pending lamp.
- `state_o`  out  3: current state encoding, for debug.

## Operation
- Tick: `tick_gen` drives a one-cycle pulse every `TICK_DIV` clocks. The first pulse occurs `TICK_DIV` clocks after `reset_n` rises.
- `ped_btn` passes through a 2-flop synchronizer followed by rising-edge detection. An edge sets `ped_req` in CAR_GREEN, CAR_YELLOW, ALL_RED_1 and ALL_RED_2. Edges in PED_WALK and PED_FLASH are ignored.
- `ped_req` clears on entry to PED_WALK. `ped_wait` = `ped_req`.
- `sec_cnt` (8 bit) clears on every state entry and increments on each tick.
- In CAR_GREEN, `sec_cnt` saturates at `T_GREEN_MIN-1`.
- All transitions occur only on tick cycles:
  - CAR_GREEN → CAR_YELLOW when `ped_req` and `sec_cnt == T_GREEN_MIN-1`. Without a request, the FSM stays in CAR_GREEN indefinitely.
  - CAR_YELLOW → ALL_RED_1 at `sec_cnt == T_YELLOW-1`.
  - ALL_RED_1 → PED_WALK at `sec_cnt == T_ALL_RED-1`.
  - PED_WALK → PED_FLASH at `sec_cnt == T_WALK-1`.
  - PED_FLASH → ALL_RED_2 at `sec_cnt == T_FLASH-1`.
  - ALL_RED_2 → CAR_GREEN at `sec_cnt == T_ALL_RED-1`.
- Lamp outputs are decoded from the state register only (Moore):
  - CAR_GREEN: `car_green`, `ped_red`.
  - CAR_YELLOW: `car_yellow`, `ped_red`.
  - ALL_RED_1, ALL_RED_2 and EMERG: `car_red`, `ped_red`.
  - PED_WALK: `car_red`, `ped_green`.
  - PED_FLASH: `car_red`; `ped_green` = `~sec_cnt[0]`, so it is on during even ticks.
- Exactly one car lamp is on at all times. Exactly one pedestrian lamp is on, except during PED_FLASH off-phases.

## Timing
- Reset values:
  - State CAR_GREEN; `sec_cnt`, `ped_req`, synchronizer flops and tick counter all 0.
  - Outputs: `car_green`=1, `ped_red`=1, all other lamps 0, `ped_wait`=0, `state_o`=0.
- Reset asserted mid-sequence returns the block to the reset values immediately, asynchronously.
- `ped_btn` rising edge to `ped_wait` high: 3 clocks.
- A tick cycle causes the state change and lamp update on the following clock edge.
- A request edge that lands in the same cycle as a tick is latched, but it is not evaluated until the next tick.
- Minimum request-to-WALK latency is `T_YELLOW + T_ALL_RED` ticks, measured from a request made after the minimum green has elapsed.
- Tick counter width is `$clog2(TICK_DIV)`. It wraps to 0 at `TICK_DIV-1` and is free-running, independent of state.

## Configuration
- `TRAFFIC_EMERGENCY_EN` defined:
  - Adds the `emergency` port (2-flop synchronized) and the EMERG state.
  - A synchronized high moves the FSM to EMERG from any state on the next clock, without waiting for a tick. `sec_cnt` is cleared.
  - On release, the FSM goes from EMERG to ALL_RED_2 with `sec_cnt` = 0, then continues the normal sequence.
  - `ped_req` is preserved and still latches during EMERG.
- `TRAFFIC_EMERGENCY_EN` undefined: no `emergency` port and no EMERG state; the FSM behaves as described above.

## Structure
- Package `traffic_pkg` holds:
  - `state_t` enum: CAR_GREEN=0, CAR_YELLOW=1, ALL_RED_1=2, PED_WALK=3, PED_FLASH=4, ALL_RED_2=5, EMERG=6.
  - Default duration constants.
  - `SEC_W` = 8.
- Sub-module `tick_gen` (parameter `TICK_DIV`; ports clk, reset_n, tick) is instantiated once.

## Test plan
All scenarios use `TICK_DIV`=4 and default durations.
- Reset, no button, 200 clocks → state CAR_GREEN throughout, `car_green`=1, `ped_red`=1, `ped_wait`=0.
- Button pulse at clock 10 → `ped_wait` high at clock 13. Yellow starts after tick 10, ALL_RED_1 after tick 13, WALK after tick 14, WALK lasts 8 ticks, then flash `ped_green` 1,0,1,0 on consecutive ticks, ALL_RED_2 for 1 tick, then CAR_GREEN with `ped_wait`=0.
- Button pressed during PED_WALK → ignored; `ped_wait` stays 0; after returning, CAR_GREEN holds indefinitely.
- Button pressed during ALL_RED_2 → `ped_wait`=1 persists; the next YELLOW begins exactly 10 ticks after re-entry to CAR_GREEN.
- `reset_n` low for 1 clock mid-PED_FLASH → outputs return to reset values within the same cycle; the first tick comes 4 clocks after release.
- With `TRAFFIC_EMERGENCY_EN`, `emergency` high during CAR_GREEN → EMERG 3 clocks later with `car_red`=1 and `ped_red`=1. On release → ALL_RED_2 for 1 tick, then CAR_GREEN; a request latched during EMERG is still served.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared states, default durations and counter helpers for traffic_ctrl
package traffic_pkg;

   localparam int SEC_W = 8;

   localparam int DEF_TICK_DIV    = 100_000_000;
   localparam int DEF_T_GREEN_MIN = 10;
   localparam int DEF_T_YELLOW    = 3;
   localparam int DEF_T_ALL_RED   = 1;
   localparam int DEF_T_WALK      = 8;
   localparam int DEF_T_FLASH     = 4;

   typedef enum logic [2:0] {
      CAR_GREEN  = 3'd0,
      CAR_YELLOW = 3'd1,
      ALL_RED_1  = 3'd2,
      PED_WALK   = 3'd3,
      PED_FLASH  = 3'd4,
      ALL_RED_2  = 3'd5,
      EMERG      = 3'd6
   } state_t;

   // Final sec_cnt value of a phase lasting the given number of ticks.
   function automatic logic [SEC_W-1:0] last_cnt(input int ticks);
      return SEC_W'(ticks - 1);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   // Registered pulse: first tick is visible TICK_DIV clocks after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == CNT_LAST);
         cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - pedestrian-priority crossing sequencer; TRAFFIC_EMERGENCY_EN adds emergency all-red
module traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
   parameter int T_YELLOW    = DEF_T_YELLOW,
   parameter int T_ALL_RED   = DEF_T_ALL_RED,
   parameter int T_WALK      = DEF_T_WALK,
   parameter int T_FLASH     = DEF_T_FLASH
) (
   input  logic       clk_100MHz,
   input  logic       reset_n,
   input  logic       ped_btn,
`ifdef TRAFFIC_EMERGENCY_EN
   input  logic       emergency,
`endif
   output logic       car_red,
   output logic       car_yellow,
   output logic       car_green,
   output logic       ped_red,
   output logic       ped_green,
   output logic       ped_wait,
   output logic [2:0] state_o
);

   localparam logic [SEC_W-1:0] GREEN_LAST  = last_cnt(T_GREEN_MIN);
   localparam logic [SEC_W-1:0] YELLOW_LAST = last_cnt(T_YELLOW);
   localparam logic [SEC_W-1:0] RED_LAST    = last_cnt(T_ALL_RED);
   localparam logic [SEC_W-1:0] WALK_LAST   = last_cnt(T_WALK);
   localparam logic [SEC_W-1:0] FLASH_LAST  = last_cnt(T_FLASH);

   state_t           state, state_nx;
   logic [SEC_W-1:0] sec_cnt;
   logic             ped_req;
   logic             tick;
   logic             btn_s1, btn_s2, btn_s3;
   logic             btn_rise;
   logic             emerg_act;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk     (clk_100MHz),
      .reset_n (reset_n),
      .tick    (tick)
   );

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         btn_s3 <= 1'b0;
      end else begin
         btn_s1 <= ped_btn;
         btn_s2 <= btn_s1;
         btn_s3 <= btn_s2;
      end
   end

   assign btn_rise = btn_s2 & ~btn_s3;

`ifdef TRAFFIC_EMERGENCY_EN
   logic emerg_s1, emerg_s2;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         emerg_s1 <= 1'b0;
         emerg_s2 <= 1'b0;
      end else begin
         emerg_s1 <= emergency;
         emerg_s2 <= emerg_s1;
      end
   end

   assign emerg_act = emerg_s2;
`else
   assign emerg_act = 1'b0;
`endif

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state   <= CAR_GREEN;
         sec_cnt <= '0;
         ped_req <= 1'b0;
      end else begin
         state <= state_nx;

         if (state_nx != state)
            sec_cnt <= '0;
         else if (tick && !(state == CAR_GREEN && sec_cnt == GREEN_LAST))
            sec_cnt <= sec_cnt + SEC_W'(1);

         // Entry to WALK serves the request; presses during WALK/FLASH are dropped.
         if (state_nx == PED_WALK && state != PED_WALK)
            ped_req <= 1'b0;
         else if (btn_rise && state != PED_WALK && state != PED_FLASH)
            ped_req <= 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      car_red    = 1'b0;
      car_yellow = 1'b0;
      car_green  = 1'b0;
      ped_red    = 1'b0;
      ped_green  = 1'b0;

      if (tick) begin
         case (state)
            CAR_GREEN:  if (ped_req && sec_cnt == GREEN_LAST) state_nx = CAR_YELLOW;
            CAR_YELLOW: if (sec_cnt == YELLOW_LAST)           state_nx = ALL_RED_1;
            ALL_RED_1:  if (sec_cnt == RED_LAST)              state_nx = PED_WALK;
            PED_WALK:   if (sec_cnt == WALK_LAST)             state_nx = PED_FLASH;
            PED_FLASH:  if (sec_cnt == FLASH_LAST)            state_nx = ALL_RED_2;
            ALL_RED_2:  if (sec_cnt == RED_LAST)              state_nx = CAR_GREEN;
            default:    ;
         endcase
      end

      // Emergency overrides the tick schedule in both directions.
      if (emerg_act)
         state_nx = EMERG;
      else if (state == EMERG)
         state_nx = ALL_RED_2;

      case (state)
         CAR_GREEN: begin
            car_green = 1'b1;
            ped_red   = 1'b1;
         end
         CAR_YELLOW: begin
            car_yellow = 1'b1;
            ped_red    = 1'b1;
         end
         PED_WALK: begin
            car_red   = 1'b1;
            ped_green = 1'b1;
         end
         PED_FLASH: begin
            car_red   = 1'b1;
            ped_green = ~sec_cnt[0];
         end
         default: begin
            car_red = 1'b1;
            ped_red = 1'b1;
         end
      endcase
   end

   assign ped_wait = ped_req;
   assign state_o  = state;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - directed self-checking bench for traffic_ctrl with TICK_DIV=4
module tb_traffic_ctrl;

   localparam logic [8:0] L_GREEN   = 9'b001_10_0_000;
   localparam logic [8:0] L_GREEN_W = 9'b001_10_1_000;
   localparam logic [8:0] L_YEL_W   = 9'b010_10_1_001;
   localparam logic [8:0] L_AR1_W   = 9'b100_10_1_010;
   localparam logic [8:0] L_WALK    = 9'b100_01_0_011;
   localparam logic [8:0] L_FL_ON   = 9'b100_01_0_100;
   localparam logic [8:0] L_FL_OFF  = 9'b100_00_0_100;
   localparam logic [8:0] L_AR2     = 9'b100_10_0_101;
   localparam logic [8:0] L_AR2_W   = 9'b100_10_1_101;

   logic       clk_100MHz = 1'b0;
   logic       reset_n    = 1'b0;
   logic       ped_btn    = 1'b0;
   logic       emergency  = 1'b0;
   logic       car_red, car_yellow, car_green;
   logic       ped_red, ped_green, ped_wait;
   logic [2:0] state_o;
   logic [8:0] lamps;

   int total  = 0;
   int bad    = 0;
   int ecount = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   traffic_ctrl #(.TICK_DIV(4)) dut (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .ped_btn    (ped_btn),
`ifdef TRAFFIC_EMERGENCY_EN
      .emergency  (emergency),
`endif
      .car_red    (car_red),
      .car_yellow (car_yellow),
      .car_green  (car_green),
      .ped_red    (ped_red),
      .ped_green  (ped_green),
      .ped_wait   (ped_wait),
      .state_o    (state_o)
   );

   assign lamps = {car_red, car_yellow, car_green, ped_red, ped_green, ped_wait, state_o};

   task automatic cyc(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk_100MHz);
         #1;
         ecount += n;
      end
   endtask

   task automatic goto(input int n);
      cyc(n - ecount);
   endtask

   task automatic do_reset;
      reset_n   = 1'b0;
      ped_btn   = 1'b0;
      emergency = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      ecount  = 0;
   endtask

   task automatic start_request;
      do_reset();
      goto(10);
      ped_btn = 1'b1;
      goto(14);
      ped_btn = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      cyc(2);
      total++;
      if (lamps !== L_GREEN) begin
         bad++;
         $display("FAIL reset_hold lamps=%b want %b", lamps, L_GREEN);
      end
      reset_n = 1'b1;
      ecount  = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         total++;
         if (lamps !== L_GREEN) begin
            bad++;
            $display("FAIL idle_green @%0d lamps=%b want %b", ecount, lamps, L_GREEN);
         end
      end
   endtask

   task automatic test_ped_cycle;
      int         at  [16] = '{40, 41, 52, 53, 56, 57, 88, 89, 93, 97, 101, 104, 105, 108, 109, 150};
      logic [8:0] exp [16] = '{L_GREEN_W, L_YEL_W, L_YEL_W, L_AR1_W, L_AR1_W, L_WALK, L_WALK,
                               L_FL_ON, L_FL_OFF, L_FL_ON, L_FL_OFF, L_FL_OFF, L_AR2, L_AR2,
                               L_GREEN, L_GREEN};
      do_reset();
      goto(10);
      ped_btn = 1'b1;
      goto(12);
      total++;
      if (lamps !== L_GREEN) begin
         bad++;
         $display("FAIL wait_early @12 lamps=%b want %b", lamps, L_GREEN);
      end
      goto(13);
      total++;
      if (lamps !== L_GREEN_W) begin
         bad++;
         $display("FAIL wait_latency @13 lamps=%b want %b", lamps, L_GREEN_W);
      end
      goto(14);
      ped_btn = 1'b0;
      for (int i = 0; i < 16; i++) begin
         goto(at[i]);
         total++;
         if (lamps !== exp[i]) begin
            bad++;
            $display("FAIL ped_cycle @%0d lamps=%b want %b", ecount, lamps, exp[i]);
         end
      end
   endtask

   task automatic test_press_in_walk;
      int         at  [7] = '{64, 88, 89, 105, 109, 200, 400};
      logic [8:0] exp [7] = '{L_WALK, L_WALK, L_FL_ON, L_AR2, L_GREEN, L_GREEN, L_GREEN};
      start_request();
      goto(60);
      ped_btn = 1'b1;
      goto(64);
      ped_btn = 1'b0;
      for (int i = 0; i < 7; i++) begin
         goto(at[i]);
         total++;
         if (lamps !== exp[i]) begin
            bad++;
            $display("FAIL walk_press @%0d lamps=%b want %b", ecount, lamps, exp[i]);
         end
      end
   endtask

   task automatic test_press_in_all_red;
      int         at  [4] = '{108, 109, 148, 149};
      logic [8:0] exp [4] = '{L_AR2_W, L_GREEN_W, L_GREEN_W, L_YEL_W};
      start_request();
      goto(105);
      ped_btn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         goto(at[i]);
         if (ecount == 109) ped_btn = 1'b0;
         total++;
         if (lamps !== exp[i]) begin
            bad++;
            $display("FAIL ar2_press @%0d lamps=%b want %b", ecount, lamps, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_flash;
      start_request();
      goto(91);
      total++;
      if (lamps !== L_FL_ON) begin
         bad++;
         $display("FAIL pre_reset_flash lamps=%b want %b", lamps, L_FL_ON);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (lamps !== L_GREEN) begin
         bad++;
         $display("FAIL async_reset lamps=%b want %b", lamps, L_GREEN);
      end
      @(posedge clk_100MHz);
      #1;
      reset_n = 1'b1;
      ecount  = 0;
      goto(10);
      ped_btn = 1'b1;
      goto(14);
      ped_btn = 1'b0;
      goto(40);
      total++;
      if (lamps !== L_GREEN_W) begin
         bad++;
         $display("FAIL post_reset_green @40 lamps=%b want %b", lamps, L_GREEN_W);
      end
      goto(41);
      total++;
      if (lamps !== L_YEL_W) begin
         bad++;
         $display("FAIL post_reset_yellow @41 lamps=%b want %b", lamps, L_YEL_W);
      end
   endtask

`ifdef TRAFFIC_EMERGENCY_EN
   task automatic test_emergency;
      int         at  [7] = '{22, 23, 27, 44, 45, 84, 85};
      logic [8:0] exp [7] = '{L_GREEN, 9'b100_10_0_110, 9'b100_10_1_110, L_AR2_W,
                              L_GREEN_W, L_GREEN_W, L_YEL_W};
      do_reset();
      goto(20);
      emergency = 1'b1;
      for (int i = 0; i < 7; i++) begin
         goto(at[i]);
         total++;
         if (lamps !== exp[i]) begin
            bad++;
            $display("FAIL emergency @%0d lamps=%b want %b", ecount, lamps, exp[i]);
         end
         if (ecount == 23) begin
            goto(24);
            ped_btn = 1'b1;
         end else if (ecount == 27) begin
            ped_btn = 1'b0;
            goto(40);
            emergency = 1'b0;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ped_cycle();
      test_press_in_walk();
      test_press_in_all_red();
      test_reset_mid_flash();
`ifdef TRAFFIC_EMERGENCY_EN
      test_emergency();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
